// File: rtl/spi_ram_btn_fifo.sv
// SPI RAM read/write slave with debounced buttons, a press/release event FIFO
// and three register windows mapped over the BRAM address space.

module spirw_slave_v #(
    parameter int c_addr_bits        = 32,
    parameter int c_sclk_capable_pin = 0
) (
    input  logic                   clk,
    input  logic                   csn,
    input  logic                   sclk,
    input  logic                   mosi,
    inout  wire                    miso,
    output logic                   rd,
    output logic                   wr,
    output logic [c_addr_bits-1:0] addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out
);
    // Protocol: byte0 = command (bit0: 1 read, 0 write), bytes1..4 = address MSB first,
    // then write data, or for a read one dummy byte followed by read data.
    logic [2:0] sclk_s_q, sclk_s_d;
    logic [1:0] csn_s_q, csn_s_d, mosi_s_q, mosi_s_d;
    logic sclk_cur, sclk_prev, csn_cur, mosi_cur, rise, fall;
    logic [2:0] bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d, ld_q, ld_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, data_out_q, data_out_d, byte_v;
    logic is_read_q, is_read_d, rd_q, rd_d, wr_q, wr_d;
    logic [c_addr_bits-1:0] addr_q, addr_d;

    // A clock-capable sclk pin is cleaner, so one synchronizer stage is dropped for it.
    assign sclk_cur  = (c_sclk_capable_pin != 0) ? sclk_s_q[0] : sclk_s_q[1];
    assign sclk_prev = (c_sclk_capable_pin != 0) ? sclk_s_q[1] : sclk_s_q[2];
    assign csn_cur   = (c_sclk_capable_pin != 0) ? csn_s_q[0]  : csn_s_q[1];
    assign mosi_cur  = (c_sclk_capable_pin != 0) ? mosi_s_q[0] : mosi_s_q[1];
    assign rise      = sclk_cur & ~sclk_prev;
    assign fall      = ~sclk_cur & sclk_prev;

    // Byte assembly, address load/increment, strobes and the MISO shifter.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sclk_s_d   = {sclk_s_q[1:0], sclk};
        csn_s_d    = {csn_s_q[0], csn};
        mosi_s_d   = {mosi_s_q[0], mosi};
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        data_out_d = data_out_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        ld_d       = {ld_q[1:0], 1'b0};
        byte_v     = {rx_q[6:0], mosi_cur};
        // The falling edge right after a completed byte must not shift, the MSB is freshly loaded.
        if (fall && !csn_cur && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
        // Capture read data after the previous byte's strobe has settled (FIFO head moved on).
        if (ld_q[2]) tx_d = data_in;
        if (rd_q || wr_q) addr_d = addr_q + 1'b1;
        if (csn_cur) begin
            bit_cnt_d  = 3'd0;
            byte_idx_d = 3'd0;
        end else if (rise) begin
            rx_d      = byte_v;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
                if (byte_idx_q != 3'd7) byte_idx_d = byte_idx_q + 1'b1;
                case (byte_idx_q)
                    3'd0: is_read_d = byte_v[0];
                    3'd1, 3'd2, 3'd3, 3'd4: addr_d = {addr_q[c_addr_bits-9:0], byte_v};
                    default: begin
                        if (is_read_q) begin
                            // The strobe marks a byte actually shifted out, so nothing is consumed speculatively.
                            ld_d[0] = 1'b1;
                            if (byte_idx_q >= 3'd6) rd_d = 1'b1;
                        end else begin
                            data_out_d = byte_v;
                            wr_d       = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State register; this core deliberately has no reset, csn high re-synchronises it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        sclk_s_q   <= sclk_s_d;
        csn_s_q    <= csn_s_d;
        mosi_s_q   <= mosi_s_d;
        bit_cnt_q  <= bit_cnt_d;
        byte_idx_q <= byte_idx_d;
        rx_q       <= rx_d;
        tx_q       <= tx_d;
        data_out_q <= data_out_d;
        is_read_q  <= is_read_d;
        addr_q     <= addr_d;
        rd_q       <= rd_d;
        wr_q       <= wr_d;
        ld_q       <= ld_d;
    end

    assign miso     = csn ? 1'bz : tx_q[7];
    assign rd       = rd_q;
    assign wr       = wr_q;
    assign addr     = addr_q;
    assign data_out = data_out_q;
endmodule

module spi_ram_btn_fifo #(
    parameter logic [7:0]  c_addr_btn        = 8'hFB,
    parameter logic [7:0]  c_addr_irq        = 8'hF1,
    parameter logic [7:0]  c_addr_evt        = 8'hF2,
    parameter int          c_btn_count       = 7,
    parameter logic [c_btn_count-1:0] c_force_mask = 7'h78,
    parameter int          c_debounce_bits   = 20,
    parameter int          c_fifo_depth_log2 = 3,
    parameter int          c_addr_bits       = 32,
    parameter int          c_sclk_capable_pin = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   csn,
    input  logic                   sclk,
    input  logic                   mosi,
    inout  wire                    miso,
    input  logic [c_btn_count-1:0] btn,
    input  logic                   f1_pressed,
    output logic                   irq,
    output logic                   rd,
    output logic                   wr,
    output logic [c_addr_bits-1:0] addr,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out
);
    localparam int c_depth = 1 << c_fifo_depth_log2;

    logic s_rd, s_wr;
    logic [7:0] s_din, hi, reg_rdata, evt;
    logic win_btn, win_irq, win_evt, in_win;
    logic [c_btn_count-1:0] sync1_q, sync1_d, sync2_q, sync2_d, r_btn_q, r_btn_d, r_rep_q, r_rep_d, diff;
    logic [1:0] cnt_q [c_btn_count];
    logic [1:0] cnt_d [c_btn_count];
    logic [c_debounce_bits-1:0] presc_q, presc_d;
    logic [7:0] mem_q [c_depth];
    logic [c_fifo_depth_log2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_fifo_depth_log2:0] count_q, count_d;
    logic ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d, rd_prev_q;
    logic tick, push, do_push, pop, full, nonempty, irq_wr, flush, clr_ovf, en_wr;
    logic [31:0] btn_pad;

    spirw_slave_v #(
        .c_addr_bits       (c_addr_bits),
        .c_sclk_capable_pin(c_sclk_capable_pin)
    ) u_spi (
        .clk(clk), .csn(csn), .sclk(sclk), .mosi(mosi), .miso(miso),
        .rd(s_rd), .wr(s_wr), .addr(addr), .data_in(s_din), .data_out(data_out)
    );

    assign hi       = addr[c_addr_bits-1 -: 8];
    assign win_btn  = (hi == c_addr_btn);
    assign win_irq  = (hi == c_addr_irq);
    assign win_evt  = (hi == c_addr_evt);
    assign in_win   = win_btn | win_irq | win_evt;
    assign rd       = s_rd & ~in_win;
    assign wr       = s_wr & ~in_win;
    assign tick     = &presc_q;
    assign full     = count_q[c_fifo_depth_log2];
    assign nonempty = |count_q;
    assign irq_wr   = s_wr & win_irq;
    assign flush    = irq_wr & (addr[1:0] == 2'd0) & data_out[7];
    assign clr_ovf  = irq_wr & (addr[1:0] == 2'd0) & data_out[6];
    assign en_wr    = irq_wr & (addr[1:0] == 2'd1);
    assign pop      = rd_prev_q & ~s_rd & win_evt & nonempty;
    assign irq      = irq_q;

    // Synchronizer, tick prescaler and per-button 3-tick stability filter.
    always_comb begin
        sync1_d = f1_pressed ? c_force_mask : btn;
        sync2_d = sync1_q;
        presc_d = presc_q + 1'b1;
        r_btn_d = r_btn_q;
        for (int i = 0; i < c_btn_count; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == r_btn_q[i]) begin
                cnt_d[i] = 2'd0;
            end else if (tick) begin
                if (cnt_q[i] == 2'd2) begin
                    r_btn_d[i] = sync2_q[i];
                    cnt_d[i]   = 2'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index change scanner feeding the FIFO, plus the IRQ window write actions.
    always_comb begin
        diff     = r_btn_q ^ r_rep_q;
        r_rep_d  = r_rep_q;
        push     = 1'b0;
        evt      = 8'h00;
        for (int i = 0; i < c_btn_count; i++) begin
            if (diff[i] && !push) begin
                push       = 1'b1;
                r_rep_d[i] = r_btn_q[i];
                evt        = {1'b1, ~r_btn_q[i], 6'(i)};
            end
        end
        do_push  = push & (~full | pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !pop) count_d = count_q + 1'b1;
            else if (!do_push && pop) count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (push && full && !pop && !flush) ovf_d = 1'b1;
        irq_en_d = en_wr ? data_out[0] : irq_en_q;
        irq_d    = irq_en_q & (nonempty | ovf_q);
    end

    // Register read mux; sits combinationally in front of the slave's read data like BRAM.
    always_comb begin
        btn_pad   = 32'(r_btn_q);
        reg_rdata = 8'h00;
        if (win_btn) begin
            case (addr[1:0])
                2'd0: reg_rdata = btn_pad[7:0];
                2'd1: reg_rdata = btn_pad[15:8];
                2'd2: reg_rdata = btn_pad[23:16];
                default: reg_rdata = btn_pad[31:24];
            endcase
        end else if (win_irq) begin
            if (addr[1:0] == 2'd0) reg_rdata = {irq_q, ovf_q, nonempty, 5'b0};
            else if (addr[1:0] == 2'd1) reg_rdata = {7'b0, irq_en_q};
        end else if (win_evt) begin
            reg_rdata = nonempty ? mem_q[rd_ptr_q] : 8'h00;
        end
        s_din = in_win ? reg_rdata : data_in;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            presc_q   <= '0;
            r_btn_q   <= '0;
            r_rep_q   <= '0;
            for (int i = 0; i < c_btn_count; i++) cnt_q[i] <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b1;
            irq_q     <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            presc_q   <= presc_d;
            r_btn_q   <= r_btn_d;
            r_rep_q   <= r_rep_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            rd_prev_q <= s_rd;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count/pointers gate every read of it.
        if (do_push) mem_q[wr_ptr_q] <= evt;
    end
endmodule
